// File: rtl/visca_cmd_tx_if.sv
// VISCA command transmitter bus: request/status handshake,
// command ROM port and UART line.
interface visca_cmd_tx_if;
    logic       start;
    logic [2:0] speed;
    logic [2:0] rom_ad;
    logic [7:0] rom_dout;
    logic       tx;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, speed, rom_dout,
        input  rom_ad, tx, busy, done, err
    );

    modport slave (
        input  start, speed, rom_dout,
        output rom_ad, tx, busy, done, err
    );
endinterface

// File: rtl/visca_cmd_tx.sv
// Streams one VISCA command from a length-prefixed ROM onto an
// 8N1 UART line, splicing the latched speed nibble into one byte.
module visca_cmd_tx #(
    parameter int BAUD_DIV   = 5208,
    parameter int SPEED_ADDR = 2
) (
    input logic           clk,
    input logic           rst,
    visca_cmd_tx_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, LEN, LOAD, START, DATA, STOP, DONE
    } state_t;

    localparam logic [15:0] LAST   = 16'(BAUD_DIV - 1);
    localparam logic [2:0]  SPD_AD = 3'(SPEED_ADDR);

    state_t      state, state_d;
    logic [15:0] cnt, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [2:0]  idx, idx_d;
    logic [2:0]  speed_q, speed_d;
    logic [7:0]  shift, shift_d;
    logic        tx_q, tx_d;
    logic        err_q, err_d;
    logic        tick;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_q   <= '0;
            idx     <= '0;
            speed_q <= '0;
            shift   <= '0;
            tx_q    <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_q   <= bit_d;
            idx     <= idx_d;
            speed_q <= speed_d;
            shift   <= shift_d;
            tx_q    <= tx_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt + 16'd1;
        bit_d   = bit_q;
        idx_d   = idx;
        speed_d = speed_q;
        shift_d = shift;
        err_d   = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_d = '0;
                if (bus.start) begin
                    speed_d = bus.speed;
                    state_d = LEN;
                end
            end
            LEN: begin
                if (bus.rom_dout == 8'd0 || bus.rom_dout > 8'd7) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d   = bus.rom_dout[2:0];
                    state_d = LOAD;
                end
            end
            LOAD: begin
                shift_d = bus.rom_dout;
                if (idx == SPD_AD)
                    shift_d[3:0] = bus.rom_dout[3:0] | {1'b0, speed_q};
                state_d = START;
            end
            START: begin
                if (tick) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = {1'b0, shift[7:1]};
                    cnt_d   = '0;
                    if (bit_q == 3'd7)
                        state_d = STOP;
                    else
                        bit_d = bit_q + 3'd1;
                end
            end
            STOP: begin
                if (tick) begin
                    if (idx == 3'd1) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx - 3'd1;
                        state_d = LOAD;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d != state)
            cnt_d = '0;
        // Line level is registered from the next state, so tx never
        // sees a combinational path from the ROM or start inputs.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign bus.tx     = tx_q;
    assign bus.busy   = (state != IDLE) && (state != DONE);
    assign bus.done   = (state == DONE);
    assign bus.err    = err_q;
    assign bus.rom_ad = (state == LOAD) ? idx : 3'd0;
endmodule
